// File: rtl/mul_host_driver.sv
// Host-side driver for a combinational/approximate multiplier: request/response handshake around a
// settle window, with exact-product comparison and saturating error statistics.
module mul_host_driver #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [WIDTH-1:0]     i_req_a,
    input  logic [WIDTH-1:0]     i_req_b,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [2*WIDTH-1:0]   o_rsp_prod,
    output logic [2*WIDTH-1:0]   o_rsp_exact,
    output logic [2*WIDTH:0]     o_rsp_err,
    output logic                 o_rsp_mismatch,
    output logic                 o_rsp_ovf,
    input  logic                 i_stat_clear,
    output logic [CNT_W-1:0]     o_stat_ops,
    output logic [CNT_W-1:0]     o_stat_errs,
    output logic [2*WIDTH-1:0]   o_stat_max_abs,
    output logic [CNT_W-1:0]     o_stat_sum_abs,
    output logic [WIDTH-1:0]     o_mu_in1,
    output logic [WIDTH-1:0]     o_mu_in2,
    input  logic [2*WIDTH-1:0]   i_mu_out,
    input  logic                 i_mu_overflow
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(SETTLE + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CW-1:0]    SETTLE_C = CW'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_capture;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;

    logic [PW-1:0]      r_rsp_prod;
    logic [PW-1:0]      r_rsp_exact;
    logic [PW:0]        r_rsp_err;
    logic               r_rsp_mismatch;
    logic               r_rsp_ovf;

    logic [CNT_W-1:0]   r_stat_ops;
    logic [CNT_W-1:0]   r_stat_errs;
    logic [PW-1:0]      r_stat_max_abs;
    logic [CNT_W-1:0]   r_stat_sum_abs;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    logic [PW-1:0]      w_exact;
    logic [PW:0]        w_err;
    logic [PW-1:0]      w_abs;
    logic               w_mismatch;

    assign w_exact    = PW'(r_op_a) * PW'(r_op_b);
    assign w_err      = {1'b0, i_mu_out} - {1'b0, w_exact};
    // Magnitude taken from the operand order rather than negating the 2W+1 result; |err| fits 2W bits.
    assign w_abs      = w_err[PW] ? (w_exact - i_mu_out) : (i_mu_out - w_exact);
    assign w_mismatch = (i_mu_out != w_exact);

    logic [CNT_W-1:0]   w_base_ops;
    logic [CNT_W-1:0]   w_base_errs;
    logic [PW-1:0]      w_base_max;
    logic [CNT_W-1:0]   w_base_sum;
    logic [CNT_W-1:0]   w_ops_next;
    logic [CNT_W-1:0]   w_errs_next;
    logic [PW-1:0]      w_max_next;
    logic [SW-1:0]      w_sum_wide;
    logic [CNT_W-1:0]   w_sum_next;

    // A clear coincident with a capture wipes the old totals first, then this capture is counted.
    assign w_base_ops  = i_stat_clear ? '0 : r_stat_ops;
    assign w_base_errs = i_stat_clear ? '0 : r_stat_errs;
    assign w_base_max  = i_stat_clear ? '0 : r_stat_max_abs;
    assign w_base_sum  = i_stat_clear ? '0 : r_stat_sum_abs;

    assign w_ops_next  = (w_base_ops == CNT_MAX) ? w_base_ops : w_base_ops + CNT_W'(1);
    assign w_errs_next = (!w_mismatch || w_base_errs == CNT_MAX) ? w_base_errs
                                                                   : w_base_errs + CNT_W'(1);
    assign w_max_next  = (w_abs > w_base_max) ? w_abs : w_base_max;
    assign w_sum_wide  = SW'(w_base_sum) + SW'(w_abs);
    assign w_sum_next  = (w_sum_wide > SW'(CNT_MAX)) ? CNT_MAX : w_sum_wide[CNT_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_rsp_prod     <= '0;
            r_rsp_exact    <= '0;
            r_rsp_err      <= '0;
            r_rsp_mismatch <= 1'b0;
            r_rsp_ovf      <= 1'b0;
            r_stat_ops     <= '0;
            r_stat_errs    <= '0;
            r_stat_max_abs <= '0;
            r_stat_sum_abs <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_op_a <= i_req_a;
                r_op_b <= i_req_b;
                r_cnt  <= SETTLE_C;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_capture) begin
                r_rsp_prod     <= i_mu_out;
                r_rsp_exact    <= w_exact;
                r_rsp_err      <= w_err;
                r_rsp_mismatch <= w_mismatch;
                r_rsp_ovf      <= i_mu_overflow;
                r_stat_ops     <= w_ops_next;
                r_stat_errs    <= w_errs_next;
                r_stat_max_abs <= w_max_next;
                r_stat_sum_abs <= w_sum_next;
            end else if (i_stat_clear) begin
                r_stat_ops     <= '0;
                r_stat_errs    <= '0;
                r_stat_max_abs <= '0;
                r_stat_sum_abs <= '0;
            end
        end
    end

    assign o_req_ready    = (r_state == S_IDLE);
    assign o_rsp_valid    = (r_state == S_RESP);
    assign o_rsp_prod     = r_rsp_prod;
    assign o_rsp_exact    = r_rsp_exact;
    assign o_rsp_err      = r_rsp_err;
    assign o_rsp_mismatch = r_rsp_mismatch;
    assign o_rsp_ovf      = r_rsp_ovf;
    assign o_stat_ops     = r_stat_ops;
    assign o_stat_errs    = r_stat_errs;
    assign o_stat_max_abs = r_stat_max_abs;
    assign o_stat_sum_abs = r_stat_sum_abs;
    assign o_mu_in1       = r_op_a;
    assign o_mu_in2       = r_op_b;

endmodule

// File: tb/tb_mul_host_driver.sv
// Bench for mul_host_driver: two instances (SETTLE=1/CNT_W=16 and SETTLE=3/CNT_W=4) driven in lockstep,
// each attached to a behavioural multiplier, checked against a transaction-level reference model.
module tb_mul_host_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_a = '0;
    logic [3:0]  req_b = '0;
    logic        rsp_ready = 1'b0;
    logic        stat_clear = 1'b0;

    logic        req_ready_s1, rsp_valid_s1, mism_s1, ovf_s1, mu_ovf_s1;
    logic [7:0]  prod_s1, exact_s1, max_s1, mu_out_s1;
    logic [8:0]  err_s1;
    logic [15:0] ops_s1, errs_s1, sum_s1;
    logic [3:0]  mu_in1_s1, mu_in2_s1;

    logic        req_ready_s3, rsp_valid_s3, mism_s3, ovf_s3, mu_ovf_s3;
    logic [7:0]  prod_s3, exact_s3, max_s3, mu_out_s3;
    logic [8:0]  err_s3;
    logic [3:0]  ops_s3, errs_s3, sum_s3;
    logic [3:0]  mu_in1_s3, mu_in2_s3;

    int mode = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_host_driver #(.WIDTH(4), .SETTLE(1), .CNT_W(16)) dut_s1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready_s1), .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid_s1), .i_rsp_ready(rsp_ready),
        .o_rsp_prod(prod_s1), .o_rsp_exact(exact_s1), .o_rsp_err(err_s1),
        .o_rsp_mismatch(mism_s1), .o_rsp_ovf(ovf_s1),
        .i_stat_clear(stat_clear), .o_stat_ops(ops_s1), .o_stat_errs(errs_s1),
        .o_stat_max_abs(max_s1), .o_stat_sum_abs(sum_s1),
        .o_mu_in1(mu_in1_s1), .o_mu_in2(mu_in2_s1), .i_mu_out(mu_out_s1), .i_mu_overflow(mu_ovf_s1)
    );

    mul_host_driver #(.WIDTH(4), .SETTLE(3), .CNT_W(4)) dut_s3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready_s3), .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid_s3), .i_rsp_ready(rsp_ready),
        .o_rsp_prod(prod_s3), .o_rsp_exact(exact_s3), .o_rsp_err(err_s3),
        .o_rsp_mismatch(mism_s3), .o_rsp_ovf(ovf_s3),
        .i_stat_clear(stat_clear), .o_stat_ops(ops_s3), .o_stat_errs(errs_s3),
        .o_stat_max_abs(max_s3), .o_stat_sum_abs(sum_s3),
        .o_mu_in1(mu_in1_s3), .o_mu_in2(mu_in2_s3), .i_mu_out(mu_out_s3), .i_mu_overflow(mu_ovf_s3)
    );

    // Multiplier behaviours: 0 exact, 1 forces 7*2=12, 2 drops bit 0, 3 flips bits 2..3 by operand pattern.
    function automatic logic [7:0] mu_fn(input logic [3:0] a, input logic [3:0] b, input int md);
        logic [7:0] p;
        p = 8'(a) * 8'(b);
        case (md)
            1:       mu_fn = (a == 4'd7 && b == 4'd2) ? 8'd12 : p;
            2:       mu_fn = p & 8'hFE;
            3:       mu_fn = p ^ {4'b0000, a & b & 4'hC};
            default: mu_fn = p;
        endcase
    endfunction

    always_comb begin
        mu_out_s1 = mu_fn(mu_in1_s1, mu_in2_s1, mode);
        mu_ovf_s1 = mu_in1_s1[3] & mu_in2_s1[3];
    end

    // The slow instance sees a two-register-deep multiplier: its output is stale until two edges pass.
    logic [7:0] pipe1_out, pipe2_out;
    logic       pipe1_ovf, pipe2_ovf;
    always_ff @(posedge clk) begin
        pipe1_out <= mu_fn(mu_in1_s3, mu_in2_s3, mode);
        pipe1_ovf <= mu_in1_s3[3] & mu_in2_s3[3];
        pipe2_out <= pipe1_out;
        pipe2_ovf <= pipe1_ovf;
    end
    assign mu_out_s3 = pipe2_out;
    assign mu_ovf_s3 = pipe2_ovf;

    // Reference model: expected response fields and per-instance statistics (index 0: s1, 1: s3).
    int         e_prod, e_exact, e_mism, e_ovf;
    logic [8:0] e_err;
    int         m_ops[2], m_errs[2], m_max[2], m_sum[2];
    int         cap[2] = '{65535, 15};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ops[i] = 0; m_errs[i] = 0; m_max[i] = 0; m_sum[i] = 0;
        end
    endtask

    task automatic model_capture(input int abs_e, input int mism);
        for (int i = 0; i < 2; i++) begin
            m_ops[i] = (m_ops[i] + 1 > cap[i]) ? cap[i] : m_ops[i] + 1;
            if (mism != 0) m_errs[i] = (m_errs[i] + 1 > cap[i]) ? cap[i] : m_errs[i] + 1;
            if (abs_e > m_max[i]) m_max[i] = abs_e;
            m_sum[i] = (m_sum[i] + abs_e > cap[i]) ? cap[i] : m_sum[i] + abs_e;
        end
    endtask

    task automatic check_rsp(input string tag);
        check({tag, ".prod1"},  32'(prod_s1),  e_prod);
        check({tag, ".exact1"}, 32'(exact_s1), e_exact);
        check({tag, ".err1"},   32'(err_s1),   32'(e_err));
        check({tag, ".mism1"},  32'(mism_s1),  e_mism);
        check({tag, ".ovf1"},   32'(ovf_s1),   e_ovf);
        check({tag, ".prod3"},  32'(prod_s3),  e_prod);
        check({tag, ".exact3"}, 32'(exact_s3), e_exact);
        check({tag, ".err3"},   32'(err_s3),   32'(e_err));
        check({tag, ".mism3"},  32'(mism_s3),  e_mism);
        check({tag, ".ovf3"},   32'(ovf_s3),   e_ovf);
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".ops1"},  32'(ops_s1),  m_ops[0]);
        check({tag, ".errs1"}, 32'(errs_s1), m_errs[0]);
        check({tag, ".max1"},  32'(max_s1),  m_max[0]);
        check({tag, ".sum1"},  32'(sum_s1),  m_sum[0]);
        check({tag, ".ops3"},  32'(ops_s3),  m_ops[1]);
        check({tag, ".errs3"}, 32'(errs_s3), m_errs[1]);
        check({tag, ".max3"},  32'(max_s3),  m_max[1]);
        check({tag, ".sum3"},  32'(sum_s3),  m_sum[1]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request through both instances; response held for 'hold' extra cycles while req_valid is noise.
    task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input int hold, input bit clr,
                          input string tag);
        int p, ex, d, lat1, lat3, k;
        check({tag, ".rdy1"}, 32'(req_ready_s1), 1);
        check({tag, ".rdy3"}, 32'(req_ready_s3), 1);
        p  = int'(mu_fn(a, b, mode));
        ex = int'(a) * int'(b);
        d  = p - ex;
        req_valid = 1'b1; req_a = a; req_b = b;
        step();
        req_valid = 1'b0;
        if (clr) stat_clear = 1'b1;
        check({tag, ".in1"}, 32'(mu_in1_s3), 32'(a));
        check({tag, ".in2"}, 32'(mu_in2_s1), 32'(b));
        check({tag, ".v0"},  32'({rsp_valid_s1, rsp_valid_s3}), 0);
        lat1 = 0; lat3 = 0; k = 0;
        while ((lat1 == 0 || lat3 == 0) && k < 20) begin
            step();
            k++;
            stat_clear = 1'b0;
            if (rsp_valid_s1 && lat1 == 0) lat1 = k;
            if (rsp_valid_s3 && lat3 == 0) lat3 = k;
            if (k < 3) check({tag, ".hold_in"}, 32'(mu_in1_s3), 32'(a));
        end
        check({tag, ".lat1"}, lat1, 1);
        check({tag, ".lat3"}, lat3, 3);
        e_prod = p; e_exact = ex; e_err = 9'(d);
        e_mism = (d != 0) ? 1 : 0;
        e_ovf  = (a[3] && b[3]) ? 1 : 0;
        if (clr) model_reset();
        model_capture((d < 0) ? -d : d, e_mism);
        check_rsp(tag);
        check_stats(tag);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_a = 4'($urandom); req_b = 4'($urandom);
            step();
            check({tag, ".stall_rdy"}, 32'({req_ready_s1, req_ready_s3}), 0);
            check({tag, ".stall_v"},   32'({rsp_valid_s1, rsp_valid_s3}), 3);
            check({tag, ".stall_in"},  32'(mu_in1_s1), 32'(a));
            check_rsp({tag, ".stall"});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".drop_v"},   32'({rsp_valid_s1, rsp_valid_s3}), 0);
        check({tag, ".back_rdy"}, 32'({req_ready_s1, req_ready_s3}), 3);
    endtask

    initial begin
        model_reset();
        e_prod = 0; e_exact = 0; e_err = '0; e_mism = 0; e_ovf = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset.rdy", 32'({req_ready_s1, req_ready_s3}), 3);
        check("reset.v",   32'({rsp_valid_s1, rsp_valid_s3}), 0);
        check("reset.in",  32'({mu_in1_s1, mu_in2_s1, mu_in1_s3, mu_in2_s3}), 0);
        check_rsp("reset");
        check_stats("reset");

        mode = 0; do_txn(4'd3, 4'd5, 0, 1'b0, "exact_3x5");
        mode = 1; do_txn(4'd7, 4'd2, 0, 1'b0, "force_7x2");
        check("force.errs1", 32'(errs_s1), 1);
        check("force.max1",  32'(max_s1), 2);
        mode = 0; do_txn(4'd9, 4'd6, 5, 1'b0, "stall5");
        mode = 0; do_txn(4'd15, 4'd15, 0, 1'b0, "max_15x15");
        check("max.prod3", 32'(prod_s3), 225);

        mode = 3;
        for (int i = 0; i < 30; i++)
            do_txn(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'b0, "rand");

        // Idle clear zeroes statistics only; the held response fields stay put.
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        model_reset();
        check_stats("idle_clr");
        check_rsp("idle_clr");
        check("idle_clr.rdy", 32'({req_ready_s1, req_ready_s3}), 3);

        mode = 2;
        for (int i = 0; i < 20; i++)
            do_txn(4'($urandom_range(0, 7) * 2 + 1), 4'($urandom_range(0, 7) * 2 + 1), 0, 1'b0, "sat");
        check("sat.ops3",  32'(ops_s3), 15);
        check("sat.errs3", 32'(errs_s3), 15);
        check("sat.sum3",  32'(sum_s3), 15);
        check("sat.ops1",  32'(ops_s1), 20);

        mode = 3; do_txn(4'd13, 4'd14, 1, 1'b1, "clr_capture");
        check("clr_cap.ops1", 32'(ops_s1), 1);
        check("clr_cap.ops3", 32'(ops_s3), 1);

        // Reset while both instances sit in the settle window: nothing may come out afterwards.
        mode = 0;
        req_valid = 1'b1; req_a = 4'd11; req_b = 4'd12;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        e_prod = 0; e_exact = 0; e_err = '0; e_mism = 0; e_ovf = 0;
        check("rst_wait.rdy", 32'({req_ready_s1, req_ready_s3}), 3);
        check("rst_wait.in",  32'({mu_in1_s1, mu_in1_s3}), 0);
        check_rsp("rst_wait");
        check_stats("rst_wait");
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_wait.no_rsp", 32'({rsp_valid_s1, rsp_valid_s3}), 0);
        end

        mode = 0; do_txn(4'd6, 4'd7, 0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
